// File: rtl/sram_controller.sv
// Sequences one 32-bit load/store as two 16-bit SRAM half-accesses of WAIT_CYCLES each.
// ready drops in the request cycle and rises in the single DONE cycle (2*WAIT_CYCLES+1 cycles low).
module sram_controller #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_BASE   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [16:0]   word_q, word_d;
  logic [31:0]   data_q, data_d;
  logic          wr_q, wr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   offset;
  logic          hi_half;

  assign offset    = address - 32'(ADDR_BASE);
  assign hi_half   = (state_q == S_HIGH);
  assign read_data = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  // SRAM pins are decoded only from state and latched request, never from address.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    data_d      = data_q;
    wr_d        = wr_q;
    rdata_d     = rdata_q;
    ready       = 1'b1;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state_q)
      S_IDLE: begin
        ready = !(rd_en | wr_en);
        if (rd_en | wr_en) begin
          word_d  = 17'(offset >> 2);
          data_d  = write_data;
          wr_d    = wr_en;
          cnt_d   = '0;
          state_d = S_LOW;
        end
      end
      S_LOW, S_HIGH: begin
        ready       = 1'b0;
        sram_addr   = {word_q, hi_half};
        sram_dq_out = wr_q ? (hi_half ? data_q[31:16] : data_q[15:0]) : 16'h0;
        sram_dq_oe  = wr_q;
        sram_we_n   = !wr_q;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = hi_half ? S_DONE : S_HIGH;
          if (!wr_q) begin
            if (hi_half) rdata_d[31:16] = sram_dq_in;
            else         rdata_d[15:0]  = sram_dq_in;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle controller that sequences the off-chip 16-bit SRAM on behalf of the MEM stage, replacing the single-cycle data memory. It accepts one 32-bit read or write request from the EXE/MEM register, performs it as two 16-bit SRAM half-accesses, and holds `ready` low for the duration. While `ready` is low, the top level freezes every pipeline register and the PC.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: SRAM cycles per 16-bit half-access, ≥1.
- `ADDR_BASE`, default 1024: byte address of data-memory word 0.

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `wr_en`  in  1: write request (MEM_W_EN from EXE/MEM register).
- `rd_en`  in  1: read request (MEM_R_EN from EXE/MEM register).
- `address`  in  32: byte address (ALU result).
- `write_data`  in  32: store value.
- `read_data`  out  32: loaded word, registered.
- `ready`  out  1: 0 = access in progress, freeze pipeline.
- `sram_addr`  out  18: SRAM halfword address.
- `sram_dq_out`  out  16: data driven to SRAM.
- `sram_dq_in`  in  16: data returned by SRAM.
- `sram_dq_oe`  out  1: 1 = controller drives DQ.
- `sram_we_n`  out  1: SRAM write strobe, active-low.

## Operation
- States: IDLE, LOW, HIGH, DONE; a 2-bit state register plus a wait counter `cnt` (0..WAIT_CYCLES-1).
- IDLE:
  - `ready` = !(rd_en | wr_en), combinational, so the freeze applies in the request cycle itself.
  - On a request: latch `word = (address - ADDR_BASE) >> 2` (truncated to 17 bits), `write_data`, and op (write if `wr_en`, else read). Then go to LOW with `cnt` = 0.
- LOW:
  - `sram_addr` = {word, 1'b0}.
  - Write: `sram_dq_out` = data[15:0], `sram_dq_oe` = 1, `sram_we_n` = 0.
  - Read: `sram_dq_oe` = 0, `sram_we_n` = 1; when `cnt` = WAIT_CYCLES-1, capture `sram_dq_in` into `read_data[15:0]`.
  - `cnt` increments each cycle; at WAIT_CYCLES-1, reset `cnt` to 0 and go to HIGH.
- HIGH: same as LOW with `sram_addr` = {word, 1'b1}, data[31:16], and capture into `read_data[31:16]`. At WAIT_CYCLES-1, go to DONE.
- DONE:
  - `ready` = 1, `sram_we_n` = 1, `sram_dq_oe` = 0.
  - Always go to IDLE next cycle. The pipeline advances on this edge, so the still-asserted request is not restarted.
- `ready` = 0 in LOW and HIGH.
- `rd_en` and `wr_en` both high: treated as a write.
- Inputs changing mid-access have no effect; the latched copies are used.
- `read_data` holds its value until overwritten by the next read. A write never modifies it.
- Address arithmetic is modulo 2^32. A `word` field beyond 17 bits is silently truncated, so out-of-range addresses wrap.

## Timing
- Reset (async, any state): state = IDLE, `cnt` = 0, `read_data` = 0, `sram_addr` = 0, `sram_dq_out` = 0, `sram_dq_oe` = 0, `sram_we_n` = 1. `ready` is then 1 if no request is present.
- Reset asserted mid-access aborts the access. A partial SRAM write may remain; `read_data` is cleared.
- Request seen in IDLE at cycle 0: LOW occupies cycles 1..W, HIGH occupies cycles W+1..2W, DONE is cycle 2W+1 (W = WAIT_CYCLES).
- `ready` is low for cycles 0..2W (2W+1 cycles) and high in cycle 2W+1.
- `read_data` is valid from cycle 2W+1 onward, and must be sampled by the MEM/WB register on the DONE edge.
- Back-to-back requests: the next request is seen in IDLE at cycle 2W+2, giving exactly one DONE cycle and no idle bubble beyond IDLE's own cycle.
- No request: the controller stays in IDLE, `ready` = 1, and the SRAM bus is quiescent (`sram_we_n` = 1, `sram_dq_oe` = 0).
- All SRAM outputs are registered or decoded only from state/latched values, never directly from `address`.

## Test plan
- Reset then idle: rst pulse, no requests for 10 cycles -> `ready` = 1, `sram_we_n` = 1, `sram_dq_oe` = 0, `read_data` = 0 throughout.
- Write then read back (W = 2): `wr_en` at address 1028 with data 0xDEADBEEF -> `ready` low 5 cycles.
  - Halfword 2 receives 0xBEEF, then halfword 3 receives 0xDEAD, each with `sram_we_n` = 0 for 2 cycles.
  - A subsequent `rd_en` at 1028 -> `read_data` = 0xDEADBEEF in the DONE cycle.
- Back-to-back: read at 1024 then, immediately after DONE, write at 1032 -> second access starts in the cycle after DONE. The first access completes exactly once; SRAM sees 4 half-accesses total.
- Both enables high at 1036 with 0x12345678 -> behaves as a write; `read_data` is unchanged.
- Async reset in HIGH of a read -> outputs take their reset values immediately (before the next edge), state = IDLE, `read_data` = 0.
- WAIT_CYCLES = 1 instance: read at 1024 -> `ready` low 3 cycles, `read_data` valid in cycle 3.
